// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
// Holds the byte width, bit period, guard gap and abort timeout defaults.
package uart_tx_arbiter_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_CLKS_PER_BIT = 16;
  localparam int unsigned DEF_TX_GAP_CLKS  = 2;
  localparam int unsigned DEF_TIMEOUT_CLKS = 12 * DEF_CLKS_PER_BIT;
  localparam int unsigned CNT_W            = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: first set request at or after ptr,
// wrapping modulo N. Kept generic so a receive-side fan-out can reuse it.
module uart_tx_arbiter_rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] idx;
  int unsigned   sum;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = '0;
    sum        = 0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = 32'(ptr) + i;
      if (sum >= N) sum = sum - N;
      idx = IW'(sum);
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte producers.
// Grants one byte, holds the uart enable until done or timeout, then enforces a guard gap.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned GAP_CLKS     = DEF_TX_GAP_CLKS,
  parameter int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
  localparam int unsigned IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                          sysclk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              i_req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_data,
  output logic [N_REQ-1:0]              o_req_ready,
  output logic [N_REQ-1:0]              o_req_done,
  output logic                          o_tx_en,
  output logic [DATA_WIDTH-1:0]         o_tx_byte,
  input  logic                          i_tx_d,
  output logic                          o_busy,
  output logic [IDW-1:0]                o_grant_id,
  output logic                          o_timeout
);

  arb_state_e            state;
  logic [IDW-1:0]        ptr;
  logic [CNT_W-1:0]      cnt;
  logic [N_REQ-1:0]      gnt_onehot;
  logic [IDW-1:0]        gnt_idx;
  logic                  gnt_any;
  logic [IDW-1:0]        ptr_next;
  logic [DATA_WIDTH-1:0] req_bytes [N_REQ];

  // Unpack the flat data bus so the winner's byte is a plain array lookup.
  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_bytes[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  uart_tx_arbiter_rr_picker #(
    .N  (N_REQ),
    .IW (IDW)
  ) u_picker (
    .req        (i_req_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign ptr_next = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);

  // Grant/send/gap sequencer; pulses default low and are set for one cycle.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      o_req_ready <= '0;
      o_req_done  <= '0;
      o_tx_en     <= 1'b0;
      o_tx_byte   <= '0;
      o_busy      <= 1'b0;
      o_grant_id  <= '0;
      o_timeout   <= 1'b0;
    end else begin
      o_req_ready <= '0;
      o_req_done  <= '0;
      o_timeout   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            o_tx_byte   <= req_bytes[gnt_idx];
            o_req_ready <= gnt_onehot;
            o_grant_id  <= gnt_idx;
            o_tx_en     <= 1'b1;
            o_busy      <= 1'b1;
            ptr         <= ptr_next;
            cnt         <= '0;
            state       <= ST_SEND;
          end else begin
            o_tx_en <= 1'b0;
          end
        end
        ST_SEND: begin
          cnt <= cnt + CNT_W'(1);
          // Completion beats the abort when both land on the same cycle.
          if (i_tx_d) begin
            o_tx_en                <= 1'b0;
            o_req_done[o_grant_id] <= 1'b1;
            cnt                    <= '0;
            state                  <= ST_GAP;
          end else if (cnt == CNT_W'(TIMEOUT_CLKS - 1)) begin
            o_tx_en   <= 1'b0;
            o_timeout <= 1'b1;
            cnt       <= '0;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          o_tx_en <= 1'b0;
          if (cnt == CNT_W'(GAP_CLKS - 1)) begin
            cnt    <= '0;
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          o_tx_en <= 1'b0;
          o_busy  <= 1'b0;
          cnt     <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a cycle-level uart_tx stand-in that
// serialises the granted byte and raises done after ten bit periods.
module tb_uart_tx_arbiter;

  localparam int unsigned N         = 4;
  localparam int unsigned DW        = 8;
  localparam int unsigned CPB       = 16;
  localparam int unsigned GAP       = 2;
  localparam int unsigned TO        = 12 * CPB;
  localparam int unsigned BYTE_CLKS = 10 * CPB;

  logic            sysclk;
  logic            rst;
  logic [N-1:0]    i_req_valid;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    o_req_ready;
  logic [N-1:0]    o_req_done;
  logic            o_tx_en;
  logic [DW-1:0]   o_tx_byte;
  logic            i_tx_d;
  logic            o_busy;
  logic [1:0]      o_grant_id;
  logic            o_timeout;

  uart_tx_arbiter #(
    .N_REQ        (N),
    .DATA_WIDTH   (DW),
    .GAP_CLKS     (GAP),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_req_done  (o_req_done),
    .o_tx_en     (o_tx_en),
    .o_tx_byte   (o_tx_byte),
    .i_tx_d      (i_tx_d),
    .o_busy      (o_busy),
    .o_grant_id  (o_grant_id),
    .o_timeout   (o_timeout)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // uart_tx stand-in: dead=1 models a transmitter that never reports done.
  logic          dead;
  int unsigned   mcnt;
  logic [3:0]    bitpos;
  logic          line;
  logic [DW-1:0] rx_byte;
  logic          start_bit;
  logic          stop_bit;

  always_comb begin
    bitpos = 4'(mcnt / CPB);
    line   = 1'b1;
    if (o_tx_en) begin
      if (bitpos == 4'd0)      line = 1'b0;
      else if (bitpos <= 4'd8) line = o_tx_byte[3'(bitpos - 4'd1)];
      else                     line = 1'b1;
    end
  end

  always @(posedge sysclk or posedge rst) begin
    if (rst) begin
      mcnt   <= 0;
      i_tx_d <= 1'b0;
    end else if (!o_tx_en) begin
      mcnt   <= 0;
      i_tx_d <= 1'b0;
    end else if (!dead) begin
      i_tx_d <= (mcnt == BYTE_CLKS - 1);
      mcnt   <= mcnt + 1;
      if (mcnt % CPB == CPB / 2) begin
        if (bitpos == 4'd0)      start_bit <= line;
        else if (bitpos == 4'd9) stop_bit  <= line;
        else                     rx_byte   <= {line, rx_byte[DW-1:1]};
      end
    end
  end

  int           n_assert;
  int           n_fail;
  logic [N-1:0] seen_ready;
  logic [N-1:0] seen_done;
  int           e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
    seen_ready = seen_ready | o_req_ready;
    seen_done  = seen_done | o_req_done;
  endtask

  task automatic wait_ready(input int budget, output int edges);
    edges = 0;
    do begin tick(); edges++; end while (o_req_ready == '0 && edges < budget);
  endtask

  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    do begin tick(); edges++; end while (o_req_done == '0 && edges < budget);
  endtask

  task automatic wait_timeout(input int budget, output int edges);
    edges = 0;
    do begin tick(); edges++; end while (!o_timeout && edges < budget);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    i_req_valid = '0;
    dead        = 1'b0;
    tick();
    tick();
    rst        = 1'b0;
    seen_ready = '0;
    seen_done  = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    seen_ready  = '0;
    seen_done   = '0;
    rst         = 1'b1;
    dead        = 1'b0;
    i_req_valid = '0;
    i_req_data  = '0;
    #1;
    chk("rst_ready", 32'(o_req_ready), 32'h0);
    chk("rst_done", 32'(o_req_done), 32'h0);
    chk("rst_tx_en", 32'(o_tx_en), 32'h0);
    chk("rst_byte", 32'(o_tx_byte), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_grant", 32'(o_grant_id), 32'h0);
    chk("rst_timeout", 32'(o_timeout), 32'h0);

    // single byte from requester 1
    do_reset();
    i_req_data[1*DW +: DW] = 8'hA5;
    i_req_valid = 4'b0010;
    wait_ready(8, e);
    chk("t1_ready_lat", 32'(e), 32'd1);
    chk("t1_ready", 32'(o_req_ready), 32'h2);
    i_req_valid = '0;
    chk("t1_tx_en", 32'(o_tx_en), 32'h1);
    chk("t1_byte", 32'(o_tx_byte), 32'hA5);
    chk("t1_grant", 32'(o_grant_id), 32'd1);
    chk("t1_busy", 32'(o_busy), 32'h1);
    wait_done(400, e);
    chk("t1_done_lat", 32'(e), 32'(BYTE_CLKS + 1));
    chk("t1_done", 32'(o_req_done), 32'h2);
    chk("t1_tx_en_low", 32'(o_tx_en), 32'h0);
    chk("t1_rx", 32'(rx_byte), 32'hA5);
    chk("t1_start", 32'(start_bit), 32'h0);
    chk("t1_stop", 32'(stop_bit), 32'h1);
    tick();
    chk("t1_busy_gap", 32'(o_busy), 32'h1);
    tick();
    chk("t1_busy_idle", 32'(o_busy), 32'h0);

    // four simultaneous requesters served in index order from ptr 0
    do_reset();
    i_req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    i_req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ready(8, e);
      chk($sformatf("t2_ready%0d", i), 32'(o_req_ready), 32'(4'b0001 << i));
      chk($sformatf("t2_lat%0d", i), 32'(e), (i == 0) ? 32'd1 : 32'(GAP + 1));
      chk($sformatf("t2_byte%0d", i), 32'(o_tx_byte), 32'((i + 1) * 8'h11));
      i_req_valid[i] = 1'b0;
      wait_done(400, e);
      chk($sformatf("t2_done%0d", i), 32'(o_req_done), 32'(4'b0001 << i));
      chk($sformatf("t2_rx%0d", i), 32'(rx_byte), 32'((i + 1) * 8'h11));
    end

    // fairness between two persistent requesters
    do_reset();
    i_req_data  = {8'h00, 8'hC3, 8'h00, 8'h5A};
    i_req_valid = 4'b0101;
    for (int j = 0; j < 4; j++) begin
      wait_ready(8, e);
      chk($sformatf("t3_ready%0d", j), 32'(o_req_ready), (j % 2 == 0) ? 32'h1 : 32'h4);
      chk($sformatf("t3_byte%0d", j), 32'(o_tx_byte), (j % 2 == 0) ? 32'h5A : 32'hC3);
      wait_done(400, e);
    end
    i_req_valid = '0;
    chk("t3_no_ready_13", 32'({seen_ready[3], seen_ready[1]}), 32'h0);

    // stuck transmitter: abort after the timeout, then serve requester 1
    do_reset();
    dead        = 1'b1;
    i_req_data  = {8'h00, 8'h00, 8'h88, 8'h77};
    i_req_valid = 4'b0011;
    wait_ready(8, e);
    chk("t4_ready0", 32'(o_req_ready), 32'h1);
    i_req_valid[0] = 1'b0;
    wait_timeout(400, e);
    chk("t4_to_lat", 32'(e), 32'(TO));
    chk("t4_timeout", 32'(o_timeout), 32'h1);
    chk("t4_tx_en_low", 32'(o_tx_en), 32'h0);
    chk("t4_no_done", 32'(seen_done), 32'h0);
    dead = 1'b0;
    wait_ready(8, e);
    chk("t4_next_lat", 32'(e), 32'(GAP + 1));
    chk("t4_ready1", 32'(o_req_ready), 32'h2);
    chk("t4_byte1", 32'(o_tx_byte), 32'h88);
    i_req_valid = '0;
    wait_done(400, e);
    chk("t4_done1", 32'(o_req_done), 32'h2);
    chk("t4_done_set", 32'(seen_done), 32'h2);

    // reset during data bit 3
    do_reset();
    i_req_data  = {8'h96, 8'h00, 8'h00, 8'h3C};
    i_req_valid = 4'b0001;
    wait_ready(8, e);
    chk("t5_ready0", 32'(o_req_ready), 32'h1);
    i_req_valid = '0;
    repeat (4 * CPB + CPB / 2) tick();
    chk("t5_mid_send", 32'(o_tx_en), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx_en", 32'(o_tx_en), 32'h0);
    chk("t5_rst_busy", 32'(o_busy), 32'h0);
    chk("t5_rst_line", 32'(line), 32'h1);
    i_req_valid = 4'b1000;
    tick();
    tick();
    rst = 1'b0;
    wait_ready(8, e);
    chk("t5_ready3", 32'(o_req_ready), 32'h8);
    chk("t5_grant3", 32'(o_grant_id), 32'd3);
    i_req_valid = '0;
    wait_done(400, e);
    chk("t5_done3", 32'(o_req_done), 32'h8);
    chk("t5_rx", 32'(rx_byte), 32'h96);
    chk("t5_done_set", 32'(seen_done), 32'h8);

    // a one-cycle valid pulse during SEND is never accepted
    do_reset();
    i_req_data  = {8'h00, 8'h2B, 8'h00, 8'hE1};
    i_req_valid = 4'b0001;
    wait_ready(8, e);
    chk("t6_ready0", 32'(o_req_ready), 32'h1);
    i_req_valid = '0;
    repeat (10) tick();
    i_req_valid[2] = 1'b1;
    tick();
    i_req_valid[2] = 1'b0;
    wait_done(400, e);
    chk("t6_done0", 32'(o_req_done), 32'h1);
    repeat (10) tick();
    chk("t6_ready_set", 32'(seen_ready), 32'h1);
    chk("t6_done_set", 32'(seen_done), 32'h1);
    chk("t6_idle", 32'(o_busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
